ltc2630_spi_rx: RTL and testbench
=================================

LTC2630_SPI_RX -- requirements
Module: ltc2630_spi_rx

Interface
REQ-001 SHALL have parameter DAC_RESET_CODE, default 16'h0000, value loaded into dac_code and input_reg on reset.
REQ-002 SHALL have port clk, input, 1, the only clock; rising edge; at least 4x the sclk rate.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-004 SHALL have ports sclk / mosi / sync_n, input, 1 each, LTC2630-format SPI from the DAC-driving master, asynchronous to clk.
REQ-005 SHALL have port frame_valid, output, 1, one-cycle pulse per accepted 24-bit frame.
REQ-006 SHALL have ports cmd[3:0] / addr[3:0] / data[15:0], output, fields of the last accepted frame; held until the next accepted frame.
REQ-007 SHALL have port dac_code, output, 16, current DAC register value.
REQ-008 SHALL have port dac_update, output, 1, one-cycle pulse when dac_code is loaded.
REQ-009 SHALL have ports pd / ref_vcc, output, 1 each, power-down state / VCC-reference selected.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a bad bit count.

Function
REQ-011 SHALL pass sclk, mosi and sync_n through identical 3-flop chains (s0, s1, s2); edges SHALL be detected from s1 vs s2.
- Timing: an input first sampled at edge E0 is acted on at edge E0+2.
REQ-012 SHALL use states IDLE, SHIFT and COMMIT.
- IDLE->SHIFT on a detected sync_n fall; bit counter and shift register clear.
- SHIFT->COMMIT on a detected sync_n rise.
- COMMIT->IDLE after exactly one cycle.
REQ-013 In SHIFT, each detected sclk rise SHALL shift the s2-aligned mosi into a 24-bit register MSB-first and increment a 5-bit bit counter that saturates at 31.
REQ-014 An sclk rise detected in the same cycle as a sync_n rise SHALL be discarded.
REQ-015 On a sync_n fall while in SHIFT (a glitch), the counter and shift register SHALL clear and the state SHALL remain SHIFT.
REQ-016 In COMMIT with count==24, the outputs SHALL be set as follows.
- Fields: cmd=sr[23:20], addr=sr[19:16], data=sr[15:0].
- frame_valid SHALL be high for the cycle after COMMIT.
REQ-017 In COMMIT with count==0, nothing SHALL happen: no pulses and no state change.
REQ-018 In COMMIT with count 1..23 or >=25, frame_err SHALL pulse; cmd/addr/data and the DAC state SHALL be unchanged.
REQ-019 Accepted-frame commands SHALL take effect in the same cycle as frame_valid.
- 0000: input_reg<=data.
- 0001: dac_code<=input_reg, pd<=0, dac_update pulse.
- 0011: input_reg<=data, dac_code<=data, pd<=0, dac_update pulse.
- 0100: pd<=1.
- 0110: ref_vcc<=0.
- 0111: ref_vcc<=1.
- Any other code: frame_valid only, no state change.
REQ-020 dac_update SHALL pulse even if the new value equals the old one.
REQ-021 The block SHALL NOT drive any SPI line.

Reset
REQ-022 While rst_n=0, the block SHALL hold the following.
- State IDLE; synchronizers at sclk=0, mosi=0, sync_n=1.
- Counter 0, shift register 0.
- cmd, addr, data = 0.
- dac_code and input_reg = DAC_RESET_CODE.
- pd=0, ref_vcc=0; all pulses 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no output effect; after release, the partial frame SHALL be ignored until the next sync_n fall.

Configuration
REQ-024 With LTC2630_SPI_RX_ERRCNT_EN defined, the block SHALL add output err_count[7:0].
- Increments on each frame_err and saturates at 255.
- Reset value 0.
REQ-025 Without LTC2630_SPI_RX_ERRCNT_EN, err_count and its logic SHALL be absent and the rest of the behaviour SHALL be identical.

Verification
REQ-026 24-bit frame 0x30ABCD, sclk=clk/8 -> dac_code=0xABCD, one dac_update pulse, cmd=3, frame_valid once.
REQ-027 Frame 0x001234 then 0x100000 -> dac_code unchanged after the first frame, =0x1234 with dac_update after the second.
REQ-028 23-bit frame then 25-bit frame -> two frame_err pulses, dac_code/cmd/data unchanged; with LTC2630_SPI_RX_ERRCNT_EN, err_count=2.
REQ-029 Frame 0x400000 then 0x300001 -> pd=1 after the first frame; pd=0 and dac_code=0x0001 after the second.
REQ-030 rst_n low after 12 bits of 0x30FFFF, then a complete 0x305555 -> no effect from the partial frame, dac_code=0x5555.
REQ-031 sync_n low with 0 sclk edges, then high -> no frame_valid, no frame_err.

Source files
------------

// File: rtl/ltc2630_spi_rx.sv
// ltc2630_spi_rx: passive LTC2630 SPI frame receiver and DAC register model.
// Optional: define LTC2630_SPI_RX_ERRCNT_EN to add the saturating err_count output.
module ltc2630_spi_rx #(
    parameter logic [15:0] DAC_RESET_CODE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        sync_n,
    output logic        frame_valid,
    output logic [3:0]  cmd,
    output logic [3:0]  addr,
    output logic [15:0] data,
    output logic [15:0] dac_code,
    output logic        dac_update,
    output logic        pd,
    output logic        ref_vcc,
`ifdef LTC2630_SPI_RX_ERRCNT_EN
    output logic [7:0]  err_count,
`endif
    output logic        frame_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state;
    logic [2:0]  sclk_s, mosi_s, sync_s;
    logic [23:0] sr;
    logic [4:0]  cnt;
    logic [15:0] input_reg;
    logic        sclk_rise, sync_fall, sync_rise;

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sync_fall = ~sync_s[1] & sync_s[2];
    assign sync_rise = sync_s[1] & ~sync_s[2];

    // three-flop synchronizers; bit 0 is s0, bit 2 is s2
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sclk_s <= 3'b000;
            mosi_s <= 3'b000;
            sync_s <= 3'b111;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk};
            mosi_s <= {mosi_s[1:0], mosi};
            sync_s <= {sync_s[1:0], sync_n};
        end

    // frame FSM: shift bits while selected, decode and apply the command on commit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            cmd         <= '0;
            addr        <= '0;
            data        <= '0;
            input_reg   <= DAC_RESET_CODE;
            dac_code    <= DAC_RESET_CODE;
            pd          <= 1'b0;
            ref_vcc     <= 1'b0;
            frame_valid <= 1'b0;
            dac_update  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            dac_update  <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE:
                    if (sync_fall) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        sr    <= '0;
                    end
                SHIFT:
                    if (sync_rise) state <= COMMIT;
                    else if (sync_fall) begin
                        cnt <= '0;
                        sr  <= '0;
                    end else if (sclk_rise) begin
                        sr  <= {sr[22:0], mosi_s[2]};
                        cnt <= (cnt == 5'd31) ? cnt : cnt + 5'd1;
                    end
                default: begin
                    state <= IDLE;
                    if (cnt == 5'd24) begin
                        frame_valid <= 1'b1;
                        cmd         <= sr[23:20];
                        addr        <= sr[19:16];
                        data        <= sr[15:0];
                        case (sr[23:20])
                            4'b0000: input_reg <= sr[15:0];
                            4'b0001: begin
                                dac_code   <= input_reg;
                                pd         <= 1'b0;
                                dac_update <= 1'b1;
                            end
                            4'b0011: begin
                                input_reg  <= sr[15:0];
                                dac_code   <= sr[15:0];
                                pd         <= 1'b0;
                                dac_update <= 1'b1;
                            end
                            4'b0100: pd      <= 1'b1;
                            4'b0110: ref_vcc <= 1'b0;
                            4'b0111: ref_vcc <= 1'b1;
                            default: ;
                        endcase
                    end else if (cnt != 5'd0) frame_err <= 1'b1;
                end
            endcase
        end

`ifdef LTC2630_SPI_RX_ERRCNT_EN
    // saturating count of bad-length frames
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_count <= '0;
        else if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
endmodule

// File: tb/tb_ltc2630_spi_rx.sv
// tb_ltc2630_spi_rx: directed and randomized frames checked against a frame-level model.
module tb_ltc2630_spi_rx;
    logic clk = 0, rst_n = 0, sclk = 0, mosi = 0, sync_n = 1;
    logic frame_valid, dac_update, pd, ref_vcc, frame_err;
    logic [3:0] cmd, addr;
    logic [15:0] data, dac_code;
`ifdef LTC2630_SPI_RX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0, errors = 0;
    int fv_n = 0, du_n = 0, fe_n = 0;
    int m_fv = 0, m_du = 0, m_fe = 0, m_ec = 0;
    logic [15:0] m_in = 0, m_dac = 0, m_data = 0;
    logic [3:0] m_cmd = 0, m_addr = 0;
    logic m_pd = 0, m_ref = 0;

    ltc2630_spi_rx dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .sync_n(sync_n),
        .frame_valid(frame_valid), .cmd(cmd), .addr(addr), .data(data),
        .dac_code(dac_code), .dac_update(dac_update), .pd(pd), .ref_vcc(ref_vcc),
`ifdef LTC2630_SPI_RX_ERRCNT_EN
        .err_count(err_count),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n) begin
            fv_n += int'(frame_valid);
            du_n += int'(dac_update);
            fe_n += int'(frame_err);
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dac_code"}, 32'(dac_code), 32'(m_dac));
        check({tag, ".pd"}, 32'(pd), 32'(m_pd));
        check({tag, ".ref_vcc"}, 32'(ref_vcc), 32'(m_ref));
        check({tag, ".cmd"}, 32'(cmd), 32'(m_cmd));
        check({tag, ".addr"}, 32'(addr), 32'(m_addr));
        check({tag, ".data"}, 32'(data), 32'(m_data));
        check({tag, ".n_valid"}, 32'(fv_n), 32'(m_fv));
        check({tag, ".n_update"}, 32'(du_n), 32'(m_du));
        check({tag, ".n_err"}, 32'(fe_n), 32'(m_fe));
`ifdef LTC2630_SPI_RX_ERRCNT_EN
        check({tag, ".err_count"}, 32'(err_count), 32'(m_ec));
`endif
    endtask

    // frame-level reference: what a whole frame of n bits does to the visible state
    task automatic model(input logic [31:0] v, input int n);
        if (n == 0) return;
        if (n != 24) begin
            m_fe++;
            if (m_ec < 255) m_ec++;
            return;
        end
        m_fv++;
        {m_cmd, m_addr, m_data} = v[23:0];
        case (m_cmd)
            4'h0: m_in = m_data;
            4'h1: begin m_dac = m_in; m_pd = 0; m_du++; end
            4'h3: begin m_in = m_data; m_dac = m_data; m_pd = 0; m_du++; end
            4'h4: m_pd = 1;
            4'h6: m_ref = 0;
            4'h7: m_ref = 1;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_in = 0; m_dac = 0; m_data = 0; m_cmd = 0; m_addr = 0;
        m_pd = 0; m_ref = 0; m_ec = 0;
    endtask

    // SPI master at sclk = clk/8; cut > 0 resets the DUT after that many bits
    task automatic send(input logic [31:0] v, input int n, input int cut = 0);
        sync_n = 0;
        #40;
        for (int i = n - 1; i >= 0; i--) begin
            if (cut > 0 && (n - 1 - i) == cut) begin
                #20 rst_n = 0;
                sclk = 0; mosi = 0; sync_n = 1;
                #30 rst_n = 1;
                #100;
                model_reset();
                return;
            end
            mosi = v[i];
            sclk = 0;
            #40 sclk = 1;
            #40;
        end
        sclk = 0;
        #40 sync_n = 1;
        #100;
        model(v, n);
    endtask

    logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h6, 4'h7, 4'h2, 4'hF};

    initial begin
        #23 check_all("reset_hold");
        rst_n = 1;
        #50 check_all("reset");

        send(32'h30ABCD, 24); check_all("write_update");
        check("cmd3", 32'(cmd), 32'h3);
        send(32'h001234, 24); check_all("write_only");
        send(32'h100000, 24); check_all("update_from_in");
        check("dac_1234", 32'(dac_code), 32'h1234);
        send(32'h1FFFFF, 23); send(32'h1FFFFFF, 25); check_all("bad_len");
        send(32'h400000, 24); check_all("power_down");
        check("pd_set", 32'(pd), 32'h1);
        send(32'h300001, 24); check_all("power_up");
        send(32'h700000, 24); check_all("ref_vcc");
        send(32'h30FFFF, 24, 12); check_all("abort_reset");
        send(32'h305555, 24); check_all("after_abort");
        check("dac_5555", 32'(dac_code), 32'h5555);
        send(32'h0, 0); check_all("empty_frame");
        send(32'h3FFFFF, 24); check_all("all_ones");
        send(32'h600000, 24); check_all("ref_int");

        for (int k = 0; k < 30; k++) begin
            logic [31:0] v;
            int r, n;
            v = $urandom;
            v[23:20] = codes[$urandom_range(0, 7)];
            r = $urandom_range(0, 9);
            n = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, 23) : (r == 2) ? $urandom_range(25, 30) : 24;
            send(v, n);
            check_all($sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
